maj_operand_loader: RTL
=======================

# maj_operand_loader

Sequential front-end for the 49-input combinational majority gate. It accepts operand bits as a valid/ready stream of narrow chunks and assembles them into a held-stable 49-bit vector that drives the gate's `x0..x48` inputs. After a programmable settle window it captures the gate's `y0` and returns it, with the operand Hamming weight, on a valid/ready result channel. It lets a narrow bus or on-chip test harness exercise the majority gate one vector at a time.

## Interface
- `N`, 49, operand width (odd, ≥3).
- `W`, 7, chunk width; `N` must be a multiple of `W`.
- `SETTLE_CYC`, 2, cycles the vector is held before `maj_y` is sampled (≥1).
- `HW_W`, `$clog2(N+1)` (6), Hamming-weight width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  chunk valid.
- `s_ready`  out  1  loader can accept a chunk.
- `s_data`  in  W  chunk bits; chunk k maps to `x[k*W +: W]`.
- `s_last`  in  1  marks the final chunk of a vector.
- `maj_x`  out  N  vector to the majority gate (`maj_x[i]` → `xi`).
- `maj_y`  in  1  majority gate output `y0`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumer ready.
- `m_y`  out  1  captured majority result.
- `m_hw`  out  HW_W  popcount of the vector.
- `m_short`  out  1  vector ended by `s_last` before `N/W` chunks (remainder zero-filled).
- `m_err`  out  1  `m_y` ≠ (`m_hw` ≥ (N+1)/2); only with `MAJ_REFCHECK_EN`, else tied 0.

## Operation
- FSM states: LOAD, SETTLE, CAPTURE, RESULT.
- LOAD: `s_ready`=1. On each `s_valid && s_ready`, write the chunk at index `cnt` (0..N/W-1), add the chunk's popcount to `hw`, and increment `cnt`. Go to SETTLE when `s_last` is high or `cnt == N/W-1`. If `s_last` arrives early, set `short`; unwritten bits stay 0.
- A final chunk without `s_last` still ends the vector. The next chunk starts a new vector; `s_last` is not required.
- SETTLE: `s_ready`=0. A down-counter loads `SETTLE_CYC-1` on entry and moves to CAPTURE at 0.
- CAPTURE: one cycle. Register `maj_y` into `m_y`, `hw` into `m_hw`, `short` into `m_short`, and the reference compare into `m_err`. Then go to RESULT.
- RESULT: `m_valid`=1. Outputs hold stable until `m_ready`. On handshake: clear `maj_x`, `hw`, `cnt` and `short`, deassert `m_valid`, and return to LOAD.
- `maj_x` is constant from the last chunk accept through the RESULT handshake.
- Popcount arithmetic: per-chunk popcount is ≤W, and the accumulator never exceeds N, so there is no wrap.

## Timing
- Reset values: `s_ready`=1 (state LOAD), `maj_x`=0, `m_valid`=0, `m_y`=0, `m_hw`=0, `m_short`=0, `m_err`=0, `cnt`=0.
- Latency from the last chunk accept (edge t) to `m_valid`=1 is SETTLE_CYC+1 edges.
- `s_ready` falls in the cycle after the last accept.
- First `s_ready`=1 after the result handshake is the next cycle. There is no combinational path from `m_ready` to `s_ready`.
- `m_valid` never drops without `m_ready`, and m-channel data never changes while `m_valid`=1.
- Asserting `rst_n` low in any state clears everything immediately. A partially loaded vector is discarded.

## Configuration
- `MAJ_REFCHECK_EN` defined: an internal compare sets `m_err` when `m_y != (hw >= (N+1)/2)`. This catches gate faults at runtime.
- `MAJ_REFCHECK_EN` undefined: the compare logic is not built, and `m_err` is constant 0.

## Structure
- Package `maj_pkg`: `MAJ_N`, `MAJ_W`, `MAJ_THRESH` = (N+1)/2, `MAJ_HW_W`, and the FSM state enum `maj_ld_state_t`.
- Sub-module `chunk_popcount` (W-bit in, `$clog2(W+1)`-bit out, combinational) is instantiated once.
- The majority gate itself is external. The bench instantiates the loader plus `top`.

## Test plan
- Reset, then 7 chunks of 0x7F with `s_last` on chunk 7 → `maj_x`=all ones, `m_y`=1, `m_hw`=49, `m_short`=0, `m_valid` SETTLE_CYC+1 cycles after the last accept.
- Chunks giving popcount 24, then 25 (e.g. 0x7F ×3 + 0x07, remainder 0 / 0x0F) → `m_y`=0 with `m_hw`=24; `m_y`=1 with `m_hw`=25.
- Two chunks 0x7F with `s_last` on chunk 2 → `m_short`=1, `m_hw`=14, `m_y`=0, `maj_x[48:14]`=0.
- Hold `m_ready`=0 for 10 cycles in RESULT while driving `s_valid`=1 → `s_ready`=0, outputs stable; after the handshake the next vector loads from index 0.
- Pull `rst_n` low after 3 chunks → all outputs return to reset values; the next 7 chunks form a fresh vector.
- With `MAJ_REFCHECK_EN`, force `maj_y`=0 on an all-ones vector → `m_err`=1; without the macro, `m_err`=0.

Source files
------------

// File: rtl/maj_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : maj_pkg
//  Purpose  : Shared constants and FSM state type for the majority-gate
//             operand loader.
//  Contents : MAJ_N      - operand width fed to the majority gate
//             MAJ_W      - stream chunk width
//             MAJ_THRESH - number of ones that makes the majority true
//             MAJ_HW_W   - Hamming-weight width
//             maj_ld_state_t - loader FSM states
//  Revision : 1.0 - initial release
// ============================================================================
package maj_pkg;

    localparam int MAJ_N      = 49;
    localparam int MAJ_W      = 7;
    localparam int MAJ_THRESH = (MAJ_N + 1) / 2;
    localparam int MAJ_HW_W   = $clog2(MAJ_N + 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESULT  = 2'd3
    } maj_ld_state_t;

endpackage : maj_pkg
`default_nettype wire

// File: rtl/chunk_popcount.sv
`default_nettype none
// ============================================================================
//  Module   : chunk_popcount
//  Purpose  : Combinational population count of one stream chunk.
//  Ports    : i_data  [W-1:0]  chunk bits
//             o_count [PW-1:0] number of ones in i_data
//  Revision : 1.0 - initial release
// ============================================================================
module chunk_popcount #(
    parameter int W  = 7,
    parameter int PW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [PW-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + PW'(i_data[i]);
        end
    end

endmodule : chunk_popcount
`default_nettype wire

// File: rtl/maj_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : maj_operand_loader
//  Purpose  : Assembles a stream of W-bit chunks into an N-bit vector held
//             stable on maj_x, waits SETTLE_CYC cycles, captures the external
//             majority gate output maj_y and returns it with the vector's
//             Hamming weight on a valid/ready result channel.
//  Ports    : clk, rst_n (async, active low)
//             s_valid/s_ready/s_data[W-1:0]/s_last  chunk input stream
//             maj_x[N-1:0] -> gate inputs,  maj_y <- gate output
//             m_valid/m_ready/m_y/m_hw[HW_W-1:0]/m_short/m_err  result
//  Options  : MAJ_REFCHECK_EN - when defined, m_err flags a gate result that
//             disagrees with the Hamming-weight threshold; otherwise m_err=0.
//  Revision : 1.0 - initial release
// ============================================================================
module maj_operand_loader
    import maj_pkg::*;
#(
    parameter int N          = MAJ_N,
    parameter int W          = MAJ_W,
    parameter int SETTLE_CYC = 2,
    parameter int HW_W       = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    s_data,
    input  logic            s_last,
    output logic [N-1:0]    maj_x,
    input  logic            maj_y,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_y,
    output logic [HW_W-1:0] m_hw,
    output logic            m_short,
    output logic            m_err
);

    localparam int NCH = N / W;
    localparam int CW  = $clog2(NCH + 1);
    localparam int PW  = $clog2(W + 1);
    localparam int SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    maj_ld_state_t   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW_W-1:0] hw_q, hw_d;
    logic            short_q, short_d;
    logic [N-1:0]    x_q, x_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            m_y_q, m_y_d;
    logic [HW_W-1:0] m_hw_q, m_hw_d;
    logic            m_short_q, m_short_d;

    logic [PW-1:0]   chunk_pc;
    logic            accept;
    logic            last_chunk;

    chunk_popcount #(
        .W  (W),
        .PW (PW)
    ) u_chunk_popcount (
        .i_data  (s_data),
        .o_count (chunk_pc)
    );

    assign accept     = s_valid && s_ready;
    // A vector ends on an explicit s_last or when its final slot is written.
    assign last_chunk = s_last || (cnt_q == CW'(NCH - 1));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (accept && last_chunk) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (m_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // --------------------------------------------------------- FSM outputs
    // Both handshake outputs come straight from the state register, so there
    // is no combinational path from m_ready to s_ready.
    always_comb begin
        s_ready = (state_q == ST_LOAD);
        m_valid = (state_q == ST_RESULT);
    end

    // ------------------------------------------------------------ datapath
    always_comb begin
        cnt_d     = cnt_q;
        hw_d      = hw_q;
        short_d   = short_q;
        x_d       = x_q;
        settle_d  = settle_q;
        m_y_d     = m_y_q;
        m_hw_d    = m_hw_q;
        m_short_d = m_short_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (cnt_q == CW'(k)) begin
                            x_d[k*W +: W] = s_data;
                        end
                    end
                    hw_d     = hw_q + HW_W'(chunk_pc);
                    cnt_d    = cnt_q + CW'(1);
                    settle_d = SW'(SETTLE_CYC - 1);
                    if (s_last && (cnt_q != CW'(NCH - 1))) begin
                        short_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SW'(1);
                end
            end
            ST_CAPTURE: begin
                m_y_d     = maj_y;
                m_hw_d    = hw_q;
                m_short_d = short_q;
            end
            ST_RESULT: begin
                if (m_ready) begin
                    x_d     = '0;
                    hw_d    = '0;
                    cnt_d   = '0;
                    short_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hw_q      <= '0;
            short_q   <= 1'b0;
            x_q       <= '0;
            settle_q  <= '0;
            m_y_q     <= 1'b0;
            m_hw_q    <= '0;
            m_short_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hw_q      <= hw_d;
            short_q   <= short_d;
            x_q       <= x_d;
            settle_q  <= settle_d;
            m_y_q     <= m_y_d;
            m_hw_q    <= m_hw_d;
            m_short_q <= m_short_d;
        end
    end

    assign maj_x   = x_q;
    assign m_y     = m_y_q;
    assign m_hw    = m_hw_q;
    assign m_short = m_short_q;

    // ------------------------------------------------- reference check
`ifdef MAJ_REFCHECK_EN
    localparam int THRESH = (N + 1) / 2;

    logic m_err_q, m_err_d;
    logic ref_mismatch;

    // The gate's answer must agree with the popcount threshold.
    assign ref_mismatch = maj_y != (hw_q >= HW_W'(THRESH));

    always_comb begin
        m_err_d = m_err_q;
        if (state_q == ST_CAPTURE) begin
            m_err_d = ref_mismatch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_err_q <= 1'b0;
        end else begin
            m_err_q <= m_err_d;
        end
    end

    assign m_err = m_err_q;
`else
    assign m_err = 1'b0;
`endif

endmodule : maj_operand_loader
`default_nettype wire
